clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
- Run/stop and reconfiguration controller for the team's toggle-style clock divider: owns the half-period limit, the counter and `clkout`.
- Accepts new divide limits through a valid/ready handshake and applies them only at toggle boundaries, so no runt phase is ever produced.
- Starts and stops the divided clock cleanly, always parking `clkout` low.
- Sits between the board clock (`clkin`) and logic needing a slow clock or tick, e.g. display scan and debounce.

Parameters:
- CLK_FREQ, 1000, reset-time target output frequency in Hz.
- DEFAULT_LIMIT, 50000000/2/CLK_FREQ (=25000), half-period length in `clkin` cycles loaded at reset.
- W, 32, width of counter and limit registers.

Ports:
- clkin  input  1  system clock, all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level request: 1 = produce clock, 0 = stop.
- cfg_valid  input  1  new limit offered.
- cfg_limit  input  W  offered half-period length in cycles.
- cfg_ready  output  1  controller can accept a new limit.
- cfg_err  output  1  one-cycle pulse: an accepted limit was 0 and was discarded.
- clkout  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse on the cycle `clkout` toggles.
- active  output  1  state is not STOP.
- cur_limit  output  W  limit currently in force.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state=STOP, count=0, clkout=0, tick=0;
  - cur_limit=DEFAULT_LIMIT, pend=0, cfg_ready=1, cfg_err=0, active=0.
- Handshake:
  - cfg_ready = !pend (combinational from a register).
  - Transfer occurs when cfg_valid & cfg_ready.
  - On transfer with cfg_limit!=0: pend_limit<=cfg_limit, pend<=1.
  - On transfer with cfg_limit==0: cfg_err pulses on the next cycle, pend stays 0, nothing else changes.
  - cfg_limit is sampled only at the transfer.
- Limit application: cur_limit<=pend_limit and pend<=0. This happens at whichever comes first:
  - the next toggle edge in RUN or DRAIN; the toggle itself completes the old half-period, and the new limit governs the next one;
  - any clock edge while in STOP.
- Counter and toggle (RUN and DRAIN):
  - If count >= cur_limit-1: count<=0, clkout<=~clkout, tick<=1.
  - Otherwise: count<=count+1, tick<=0.
  - Each half-period therefore lasts exactly cur_limit cycles. With limit 1, clkout toggles every cycle.
- State machine:
  - STOP: count held at 0, clkout=0.
    - run=1 -> RUN. Any pending limit is applied on the same edge, so the first half-period uses the new limit.
    - The first toggle (to 1) occurs cur_limit cycles after entering RUN.
  - RUN: counting.
    - run=0 with clkout=0 -> STOP next edge; count cleared, no tick.
    - run=0 with clkout=1 -> DRAIN; counting continues.
  - DRAIN: counting continues.
    - On the toggle to 0 -> STOP, with a tick on that edge.
    - run=1 while in DRAIN -> RUN with the counter undisturbed; the period is unaffected.
- active = (state!=STOP).
- Simultaneous events:
  - A transfer on the same edge as a toggle while pend=0 is stored as pending. It is NOT applied at that toggle; it is applied at the following toggle.
  - A transfer in STOP is applied on the next edge.
- No combinational path from any input to clkout or tick.
- Reset mid-operation (any state or phase) immediately forces clkout=0 and tick=0. pend and pend_limit are lost.

Test Plan:
1. DEFAULT_LIMIT=4; reset, run=1 -> clkout rises 4 cycles after the RUN edge, then period 8 cycles, 50% duty; tick is high exactly on each toggle cycle; active=1.
2. Running at limit 4; transfer limit 2 mid-high-phase -> current high phase stays 4 cycles; the following phases are 2 cycles each; cur_limit changes on the toggle edge; cfg_ready low from transfer until that edge.
3. Transfer limit 0 -> cfg_err is a single one-cycle pulse; cur_limit stays 4; cfg_ready stays 1; waveform is unchanged.
4. run=0 during a high phase with 2 cycles remaining -> DRAIN, clkout falls after those 2 cycles with a tick, then STOP, active=0, clkout stays 0. run=0 during a low phase -> STOP on the next edge with no tick.
5. run toggles 1->0->1 during DRAIN -> returns to RUN with no glitch; half-period stays exactly 4.
6. Assert rst asynchronously mid-high-phase with a pending limit -> clkout=0 immediately; cur_limit=DEFAULT_LIMIT; pend cleared, so the next cfg_valid is accepted at once.

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// Run/stop and reconfiguration controller for a toggle-style clock divider.
// New limits are taken via valid/ready and applied only at toggle boundaries or while stopped.
module clkdiv_ctrl #(
  parameter int unsigned  CLK_FREQ      = 1000,
  parameter int unsigned  W             = 32,
  parameter logic [W-1:0] DEFAULT_LIMIT = W'(50000000 / 2 / CLK_FREQ)
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         run,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_limit,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clkout,
  output logic         tick,
  output logic         active,
  output logic [W-1:0] cur_limit
);

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

  state_t       r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_cur_limit;
  logic [W-1:0] r_pend_limit;
  logic         r_pend;
  logic         r_clkout;
  logic         r_tick;
  logic         r_err;

  logic w_at_end;
  logic w_halt;
  logic w_toggle;
  logic w_xfer;
  logic w_apply;

  assign w_at_end = (r_count >= (r_cur_limit - W'(1)));
  // Stopping from a low phase wins over a coincident toggle: no tick, no limit update.
  assign w_halt   = (r_state == RUN) && !run && !r_clkout;
  assign w_toggle = (r_state != STOP) && !w_halt && w_at_end;
  assign w_xfer   = cfg_valid && !r_pend;
  assign w_apply  = r_pend && ((r_state == STOP) || w_toggle);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state      <= STOP;
      r_count      <= '0;
      r_cur_limit  <= DEFAULT_LIMIT;
      r_pend_limit <= '0;
      r_pend       <= 1'b0;
      r_clkout     <= 1'b0;
      r_tick       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err  <= w_xfer && (cfg_limit == '0);
      r_tick <= w_toggle;

      if (w_apply) begin
        r_cur_limit <= r_pend_limit;
        r_pend      <= 1'b0;
      end else if (w_xfer && (cfg_limit != '0)) begin
        r_pend_limit <= cfg_limit;
        r_pend       <= 1'b1;
      end

      case (r_state)
        STOP: begin
          r_count  <= '0;
          r_clkout <= 1'b0;
          if (run) r_state <= RUN;
        end
        RUN, DRAIN: begin
          if (w_halt) begin
            r_count <= '0;
            r_state <= STOP;
          end else begin
            if (w_toggle) begin
              r_count  <= '0;
              r_clkout <= ~r_clkout;
            end else begin
              r_count <= r_count + W'(1);
            end
            // With run low, any toggle reached here is high-to-low, so it parks the clock.
            if (run)           r_state <= RUN;
            else if (w_toggle) r_state <= STOP;
            else               r_state <= DRAIN;
          end
        end
        default: r_state <= STOP;
      endcase
    end
  end

  assign cfg_ready = ~r_pend;
  assign cfg_err   = r_err;
  assign clkout    = r_clkout;
  assign tick      = r_tick;
  assign active    = (r_state != STOP);
  assign cur_limit = r_cur_limit;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: vector table, hand-written corner sequences and
// randomized traffic compared against a half-period countdown model.
module tb_clkdiv_ctrl;

  localparam int unsigned DEF = 4;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_limit = '0;
  logic        cfg_ready, cfg_err, clkout, tick, active;
  logic [31:0] cur_limit;

  int checks = 0;
  int errors = 0;

  clkdiv_ctrl #(.CLK_FREQ(1000), .W(32), .DEFAULT_LIMIT(32'd4)) dut (
    .clkin(clkin), .rst(rst), .run(run), .cfg_valid(cfg_valid), .cfg_limit(cfg_limit),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clkout(clkout), .tick(tick),
    .active(active), .cur_limit(cur_limit)
  );

  always #5 clkin = ~clkin;

  // Reference model: mode 0=stopped 1=running 2=draining; m_rem counts cycles left in the half-period.
  int          m_mode;
  bit          m_out, m_tick, m_err, m_pend;
  int unsigned m_lim, m_plim, m_rem;

  function automatic void m_reset();
    m_mode = 0; m_out = 0; m_tick = 0; m_err = 0; m_pend = 0;
    m_lim = DEF; m_plim = 0; m_rem = 0;
  endfunction

  function automatic void m_step(bit r, bit v, int unsigned l);
    bit xfer;
    xfer   = v && !m_pend;
    m_err  = xfer && (l == 0);
    m_tick = 0;
    if (m_mode == 0) begin
      m_out = 0;
      if (m_pend) begin m_lim = m_plim; m_pend = 0; end
      if (r) begin m_mode = 1; m_rem = m_lim; end
    end else if (m_mode == 1 && !r && !m_out) begin
      m_mode = 0;
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_out  = !m_out;
        m_tick = 1;
        if (m_pend) begin m_lim = m_plim; m_pend = 0; end
        m_rem  = m_lim;
        m_mode = r ? 1 : 0;
      end else begin
        m_mode = r ? 1 : 2;
      end
    end
    if (xfer && l != 0) begin m_pend = 1; m_plim = l; end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    check("clkout", {31'd0, clkout}, {31'd0, m_out});
    check("tick", {31'd0, tick}, {31'd0, m_tick});
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
    check("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
    check("active", {31'd0, active}, {31'd0, (m_mode != 0)});
    check("cur_limit", cur_limit, m_lim);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [31:0] l);
    run = r; cfg_valid = v; cfg_limit = l;
    @(posedge clkin);
    m_step(r, v, l);
    @(negedge clkin);
    cmp_model();
  endtask

  task automatic do_reset();
    run = 0; cfg_valid = 0; cfg_limit = '0;
    rst = 1;
    @(negedge clkin);
    @(negedge clkin);
    rst = 0;
    m_reset();
    cmp_model();
  endtask

  typedef struct {
    logic        run, valid;
    logic [31:0] lim;
    logic        clk, tck, rdy, err, act;
    logic [31:0] cur;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // inputs {run,valid,limit} -> outputs after the edge {clkout,tick,ready,err,active,cur_limit}
    tbl[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4};
    tbl[1]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4};
    tbl[2]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4};
    tbl[3]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4};
    tbl[4]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4};
    tbl[5]  = '{1'b1, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4};
    tbl[6]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4};
    tbl[7]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4};
    tbl[8]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[9]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[10] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[11] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[12] = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[13] = '{1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2};
    tbl[14] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[15] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd2};
    tbl[16] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
    tbl[17] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2};

    m_reset();
    do_reset();
    check("rst_clkout", {31'd0, clkout}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_limit", cur_limit, 32'd4);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].run, tbl[i].valid, tbl[i].lim);
      check($sformatf("vec%0d_clkout", i), {31'd0, clkout}, {31'd0, tbl[i].clk});
      check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, tbl[i].tck});
      check($sformatf("vec%0d_ready", i), {31'd0, cfg_ready}, {31'd0, tbl[i].rdy});
      check($sformatf("vec%0d_err", i), {31'd0, cfg_err}, {31'd0, tbl[i].err});
      check($sformatf("vec%0d_active", i), {31'd0, active}, {31'd0, tbl[i].act});
      check($sformatf("vec%0d_cur", i), cur_limit, tbl[i].cur);
    end

    // Drain entered with two cycles left in the high phase, then park.
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("drain_active", {31'd0, active}, 32'd1);
    check("drain_high", {31'd0, clkout}, 32'd1);
    cyc(0, 0, 0);
    check("drain_fall", {31'd0, clkout}, 32'd0);
    check("drain_tick", {31'd0, tick}, 32'd1);
    check("drain_stop", {31'd0, active}, 32'd0);
    cyc(0, 0, 0);
    check("parked_low", {31'd0, clkout}, 32'd0);

    // run 1->0->1 inside a high phase keeps the half-period at 4.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    check("rd_rise", {31'd0, clkout}, 32'd1);
    cyc(0, 0, 0);
    check("rd_active", {31'd0, active}, 32'd1);
    cyc(1, 0, 0);
    check("rd_hold1", {31'd0, clkout}, 32'd1);
    cyc(1, 0, 0);
    check("rd_hold2", {31'd0, clkout}, 32'd1);
    check("rd_notick", {31'd0, tick}, 32'd0);
    cyc(1, 0, 0);
    check("rd_fall", {31'd0, clkout}, 32'd0);
    check("rd_tick", {31'd0, tick}, 32'd1);
    // Stop requested in the low phase: stop next edge, no tick.
    cyc(0, 0, 0);
    check("lo_stop", {31'd0, active}, 32'd0);
    check("lo_notick", {31'd0, tick}, 32'd0);

    // Asynchronous reset mid-high-phase with a pending limit.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    cyc(1, 1, 3);
    check("pre_rst_high", {31'd0, clkout}, 32'd1);
    check("pre_rst_pend", {31'd0, cfg_ready}, 32'd0);
    #2 rst = 1;
    #1;
    check("arst_clkout", {31'd0, clkout}, 32'd0);
    check("arst_tick", {31'd0, tick}, 32'd0);
    check("arst_limit", cur_limit, 32'd4);
    check("arst_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clkin);
    rst = 0;
    m_reset();
    cmp_model();
    cyc(0, 1, 5);
    check("post_rst_accept", {31'd0, cfg_ready}, 32'd0);
    cyc(0, 0, 0);
    check("post_rst_apply", cur_limit, 32'd5);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          32'($urandom_range(0, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
